// File: rtl/conv1_feed_pkg.sv
// Shared definitions for the conv1 input feed path.
// Holds activation/channel widths, the window size, the pixel type and the
// mapping from (channel, window row, window column) to a bit offset inside
// the flat conv1 activation vector.
package conv1_feed_pkg;

    localparam int DW    = 16;               // bits per activation
    localparam int CH    = 3;                // channels per pixel
    localparam int K     = 3;                // window is K x K
    localparam int PIX_W = CH * DW;          // one packed pixel
    localparam int ACT_W = K * K * CH * DW;  // one flat window

    typedef logic [PIX_W-1:0] pix_t;

    // Channel-major layout: channel c owns a K*K*DW slice, and inside it
    // tap ky*K+kx owns a DW slice (tap 0 = top-left/oldest pixel).
    function automatic int act_offset(input int c, input int ky, input int kx);
        return c * K * K * DW + (ky * K + kx) * DW;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Enable-gated delay line of DEPTH entries.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   en        : push din and advance the line by one entry
//   din       : entry written this push
//   dout      : entry pushed DEPTH pushes ago
module line_buffer #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 48
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;

    // Contents are cleared on reset only to keep simulation free of X;
    // no window ever reads an entry that was not written in the same frame.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem <= '0;
        end else if (en) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign dout = mem[DEPTH-1];

endmodule

// File: rtl/conv1_window_gen.sv
// Streaming 3x3 window generator feeding conv1.
// Accepts one CH-channel pixel per cycle in raster order, keeps two rows in
// line buffers and emits the full 3x3xCH window for every valid (no padding,
// stride 1) window position.
// Ports:
//   clk, rstn  : clock, asynchronous active-low reset
//   in_valid   : pixel present (no backpressure)
//   in_sof     : with in_valid, this pixel is row 0 / col 0
//   in_pixel   : channel c at [c*DW +: DW]
//   out_valid  : one-cycle window strobe (drives conv1.valid)
//   out_act    : flat window (drives conv1.input_act)
//   out_eof    : set with the last window of a frame
module conv1_window_gen #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int CH    = 3,
    parameter int DW    = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [CH*DW-1:0]  in_pixel,
    output logic              out_valid,
    output logic [9*CH*DW-1:0] out_act,
    output logic              out_eof
);
    import conv1_feed_pkg::*;

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0] col, cur_col;
    logic [RW-1:0] row, cur_row;
    logic          last_col, last_row, emit;

    pix_t lb1_out, lb0_out;

    logic [K-1:0][K-1:0][PIX_W-1:0] win, win_next;
    logic [9*CH*DW-1:0]             act_next;

    // lb1 delays by one row (pixel directly above), lb0 chains off lb1 for
    // the pixel two rows above.
    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk  (clk),
        .rstn (rstn),
        .en   (in_valid),
        .din  (in_pixel),
        .dout (lb1_out)
    );

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
        .clk  (clk),
        .rstn (rstn),
        .en   (in_valid),
        .din  (lb1_out),
        .dout (lb0_out)
    );

    // Position of the pixel being accepted; in_sof overrides the counters.
    always_comb begin
        cur_col  = in_sof ? '0 : col;
        cur_row  = in_sof ? '0 : row;
        last_col = (cur_col == CW'(IMG_W - 1));
        last_row = (cur_row == RW'(IMG_H - 1));
        emit     = in_valid && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
    end

    // Window after this pixel: each row shifts toward kx=0, newest column
    // comes from lb0 (top), lb1 (middle) and the incoming pixel (bottom).
    always_comb begin
        win_next = win;
        for (int ky = 0; ky < K; ky++) begin
            win_next[ky][0] = win[ky][1];
            win_next[ky][1] = win[ky][2];
        end
        win_next[0][2] = lb0_out;
        win_next[1][2] = lb1_out;
        win_next[2][2] = in_pixel;
    end

    always_comb begin
        act_next = '0;
        for (int c = 0; c < CH; c++) begin
            for (int ky = 0; ky < K; ky++) begin
                for (int kx = 0; kx < K; kx++) begin
                    act_next[act_offset(c, ky, kx) +: DW] = win_next[ky][kx][c*DW +: DW];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col       <= '0;
            row       <= '0;
            win       <= '0;
            out_valid <= 1'b0;
            out_eof   <= 1'b0;
            out_act   <= '0;
        end else if (in_valid) begin
            win       <= win_next;
            out_valid <= emit;
            out_eof   <= emit && last_row && last_col;
            if (emit) begin
                out_act <= act_next;
            end
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : cur_row + RW'(1);
            end else begin
                col <= cur_col + CW'(1);
                row <= cur_row;
            end
        end else begin
            // Gap: positions and window hold, no strobe.
            out_valid <= 1'b0;
            out_eof   <= 1'b0;
        end
    end

endmodule

// File: doc/conv1_window_gen.md
# conv1_window_gen

Streaming 3x3 window generator that produces the flat activation vector consumed by the first convolution layer (`conv1`). It accepts one 3-channel, 16-bit pixel per cycle in raster order and buffers two image rows in line buffers. It emits one complete 3x3x3 window on the 432-bit bus whenever a valid (no-padding, stride-1) window position is completed. It sits between the input-image source and `conv1`. Its outputs drive `conv1.valid` and `conv1.input_act` directly.

## Interface
Parameters:
- IMG_W, 8: image width in pixels (>= 3)
- IMG_H, 8: image height in pixels (>= 3)
- CH, 3: channels per pixel (fixed by `conv1`)
- DW, 16: bits per activation

Ports:
- clk  in  1  clock; one clock domain
- rstn  in  1  asynchronous, active-low reset
- in_valid  in  1  pixel present this cycle; there is no backpressure
- in_sof  in  1  qualified by in_valid; this pixel is (row 0, col 0)
- in_pixel  in  CH*DW (48)  channel c at [c*DW +: DW]
- out_valid  out  1  window valid; connects to `conv1.valid`
- out_act  out  9*CH*DW (432)  window; connects to `conv1.input_act`
- out_eof  out  1  asserted with the last window of a frame

## Operation
- Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) advance on each accepted pixel.
  - `col` wraps to 0 and `row` increments at the end of a row.
  - Both counters wrap to 0 after (IMG_H-1, IMG_W-1).
- in_sof & in_valid forces that pixel to be treated as (0,0), overriding the counter values. The counters continue from (0,1).
- Two line buffers, each IMG_W deep and 48 bits wide, are implemented as push-on-valid delay lines.
  - lb1 output is the pixel one row above the current pixel.
  - lb0 is fed by lb1's output and yields the pixel two rows above.
- Window register `win[ky][kx]`, with ky, kx in 0..2. On each accepted pixel, every row shifts left (kx decreasing):
  - win[2][2] <= in_pixel
  - win[1][2] <= lb1 output
  - win[0][2] <= lb0 output
- After accepting pixel (r,c), win[ky][kx] holds pixel (r-2+ky, c-2+kx).
- Window emission: an accepted pixel with row >= 2 and col >= 2 produces a window.
  - There are (IMG_H-2)*(IMG_W-2) windows per frame; the default is 36.
- out_act layout:
  - Channel c occupies [c*144 +: 144].
  - Within a channel, tap t = ky*3+kx occupies [t*16 +: 16].
  - Tap 0 is the top-left (oldest) pixel; tap 8 is the bottom-right (newest) pixel.
- out_eof is set with the window for pixel (IMG_H-1, IMG_W-1).
- Gaps in in_valid: all state holds, and out_valid stays 0 during the gap.
- Line-buffer storage needs no reset. Stale contents are never emitted, because rows 0 and 1 of every frame are written before any window that uses them.
- Reset at any point clears the counters, the window registers and all outputs. The next pixel is treated as (0,0).

## Timing
- Reset values: out_valid=0, out_eof=0, out_act=0.
- Latency: out_valid is high in the cycle immediately after the edge that accepts the completing pixel, and lasts exactly 1 cycle per window.
- out_act is stable from that edge until the next accepted pixel.
- Throughput is one window per cycle at row interiors with no bubbles. Columns 0 and 1 of each row produce no output.
- in_sof arriving mid-frame aborts the current frame. out_eof is not issued for the aborted frame.
- Back-to-back frames with no gap are supported. The first window of frame N+1 appears only after rows 0 and 1 of frame N+1 have been received.

## Structure
- Package `conv1_feed_pkg` holds:
  - DW, CH, K=3, PIX_W=CH*DW, ACT_W=K*K*CH*DW
  - a typedef `pix_t` (logic [PIX_W-1:0])
  - a function mapping (c, ky, kx) to a bit offset
- Sub-module `line_buffer` (params DEPTH, WIDTH; ports clk, rstn, en, din, dout) is an en-gated delay line of DEPTH entries. It is instantiated twice.
- The top module contains the counters, the window array, the emission logic, the out_act packing and the output registers.

## Test plan
Pixel encoding for all tests: value(ch,r,c) = ch*256 + r*16 + c, with the default 8x8 frame.
- Continuous 8x8 frame, in_sof on the first pixel:
  - exactly 36 out_valid pulses;
  - first window out_act[15:0]=0x0000, out_act[143:128]=0x0022, out_act[431:416]=0x0222;
  - out_eof only on the 36th window, whose tap 8 of channel 0 is 0x0077.
- Same frame with a random 50% in_valid duty: an identical 36-window sequence with identical out_act values, and out_valid never high in a gap cycle.
- Two frames back-to-back: 72 windows total. The 37th window has channel 0 tap 0 = 0x0000, sourced from the second frame.
- in_sof reasserted at frame 1 pixel (4,3), then a full frame sent:
  - no out_eof for the aborted frame;
  - the next window emitted follows the second in_sof and equals the first window of a clean frame.
- rstn pulsed low at pixel (5,5):
  - outputs are 0 during reset;
  - after release, a full frame gives 36 correct windows.
